// File: rtl/core_mem_mp.sv
// Multi-port data memory model: round-robin grant, shared RAM above DRAM_BASE, boot ROM below.
// Optional CORE_MEM_RANDOM_STALL_EN adds an LFSR that randomly suppresses grants.

module boot_rom #(
    parameter int DATA_WIDTH = 64
) (
    input  logic [63:0]           addr,
    output logic [DATA_WIDTH-1:0] data
);
    logic [63:0] word;

    // Address-derived pattern so every ROM word is distinct and predictable.
    assign word = {addr[63:32] ^ 32'hB007_B007, addr[31:0] & 32'hFFFF_FFF8};
    assign data = DATA_WIDTH'(word);
endmodule

module core_mem_mp #(
    parameter logic [63:0] DRAM_BASE  = 64'h8000_0000,
    parameter int          DATA_WIDTH = 64,
    parameter int          NR_PORTS   = 2,
    parameter int          ADDR_WIDTH = 24,
    parameter int          LATENCY    = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NR_PORTS-1:0]                  data_req_i,
    output logic [NR_PORTS-1:0]                  data_gnt_o,
    input  logic [NR_PORTS-1:0][63:0]            data_address_i,
    input  logic [NR_PORTS-1:0]                  data_we_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0] data_be_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]  data_wdata_i,
    output logic [NR_PORTS-1:0]                  data_rvalid_o,
    output logic [NR_PORTS-1:0][DATA_WIDTH-1:0]  data_rdata_o,
    output logic [NR_PORTS-1:0]                  data_err_o
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int BO   = $clog2(BE_W);
    localparam int PW   = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam logic [64:0] RAM_TOP = {1'b0, DRAM_BASE} + (65'd1 << (ADDR_WIDTH + BO));

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    logic [PW-1:0]         rr_q, sel, j;
    logic                  any, stall;
    logic [63:0]           sel_addr;
    logic                  sel_we;
    logic [BE_W-1:0]       sel_be;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  is_rom, is_oor, is_ram;
    logic [ADDR_WIDTH-1:0] widx;

    logic [LATENCY:1]      vld_pipe;
    logic [PW-1:0]         port_pipe [LATENCY:1];
    logic [DATA_WIDTH-1:0] data_pipe [LATENCY:1];
    logic                  err_pipe  [LATENCY:1];
    logic                  rom_q;
    logic [63:0]           addr_q;
    logic [DATA_WIDTH-1:0] rom_data, s1_data, out_data;

`ifdef CORE_MEM_RANDOM_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) lfsr_q <= 16'hACE1;
        else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign stall = ~lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // Scan from rr_q upward; first requester wins.
    always_comb begin
        data_gnt_o = '0;
        sel        = '0;
        any        = 1'b0;
        j          = '0;
        if (rst_ni && !stall) begin
            for (int i = 0; i < NR_PORTS; i++) begin
                j = PW'((int'(rr_q) + i) % NR_PORTS);
                if (!any && data_req_i[j]) begin
                    any = 1'b1;
                    sel = j;
                end
            end
            if (any) data_gnt_o[sel] = 1'b1;
        end
    end

    assign sel_addr  = data_address_i[sel];
    assign sel_we    = data_we_i[sel];
    assign sel_be    = data_be_i[sel];
    assign sel_wdata = data_wdata_i[sel];
    assign is_rom    = sel_addr < DRAM_BASE;
    assign is_oor    = {1'b0, sel_addr} >= RAM_TOP;
    assign is_ram    = !is_rom && !is_oor;
    assign widx      = sel_addr[ADDR_WIDTH+BO-1:BO];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
            rr_q     <= '0;
        end else begin
            vld_pipe[1] <= any;
            for (int i = 2; i <= LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
            if (any) rr_q <= (sel == PW'(NR_PORTS - 1)) ? '0 : sel + 1'b1;
        end
    end

    // Payload needs no reset: it is only observed behind vld_pipe.
    always_ff @(posedge clk_i) begin
        if (any && is_ram && sel_we)
            for (int b = 0; b < BE_W; b++)
                if (sel_be[b]) mem[widx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
        port_pipe[1] <= sel;
        data_pipe[1] <= (is_ram && !sel_we) ? mem[widx] : '0;
        err_pipe[1]  <= is_oor || (is_rom && sel_we);
        rom_q        <= is_rom && !sel_we;
        addr_q       <= sel_addr;
        for (int i = 2; i <= LATENCY; i++) begin
            port_pipe[i] <= port_pipe[i-1];
            err_pipe[i]  <= err_pipe[i-1];
            data_pipe[i] <= (i == 2) ? s1_data : data_pipe[i-1];
        end
    end

    boot_rom #(.DATA_WIDTH(DATA_WIDTH)) u_boot_rom (
        .addr (addr_q),
        .data (rom_data)
    );

    // ROM data joins the response right after the registered address is available.
    assign s1_data  = rom_q ? rom_data : data_pipe[1];
    assign out_data = (LATENCY == 1) ? s1_data : data_pipe[LATENCY];

    always_comb begin
        data_rvalid_o = '0;
        data_rdata_o  = '0;
        data_err_o    = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            if (vld_pipe[LATENCY] && port_pipe[LATENCY] == PW'(p)) begin
                data_rvalid_o[p] = 1'b1;
                data_rdata_o[p]  = out_data;
                data_err_o[p]    = err_pipe[LATENCY];
            end
        end
    end
endmodule

// File: tb/tb_core_mem_mp.sv
// Scoreboard bench for core_mem_mp: one LATENCY=1 and one LATENCY=3 instance share stimulus buses.

module tb_core_mem_mp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0]       req1 = '0, req3 = '0;
    logic [1:0]       gnt1, gnt3, rv1, rv3, er1, er3;
    logic [1:0][63:0] rd1, rd3;
    logic [1:0][63:0] addr = '0;
    logic [1:0]       we = '0;
    logic [1:0][7:0]  be = '0;
    logic [1:0][63:0] wdata = '0;

    typedef struct {
        int          port;
        int          cyc;
        logic [63:0] data;
        logic        err;
        bit          chk;
    } resp_t;

    resp_t sb[2][$];
    logic [63:0] mdl1 [longint];
    logic [63:0] mdl3 [longint];
    int cmp = 0, bad = 0, cyc = 0;
    int cnt [2][2];
    bit mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    core_mem_mp #(.DRAM_BASE(64'h8000_0000), .DATA_WIDTH(64), .NR_PORTS(2),
                  .ADDR_WIDTH(16), .LATENCY(1)) u_l1 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req1), .data_gnt_o(gnt1),
        .data_address_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rv1), .data_rdata_o(rd1), .data_err_o(er1));

    core_mem_mp #(.DRAM_BASE(64'h8000_0000), .DATA_WIDTH(64), .NR_PORTS(2),
                  .ADDR_WIDTH(16), .LATENCY(3)) u_l3 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req3), .data_gnt_o(gnt3),
        .data_address_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rv3), .data_rdata_o(rd3), .data_err_o(er3));

    // Reference behaviour of one granted access; updates the memory model on writes.
    function automatic resp_t model(input int inst, input int p, input logic [63:0] a,
                                    input bit w, input logic [7:0] b, input logic [63:0] d);
        resp_t e;
        longint k;
        logic [63:0] old;
        e.port = p;
        e.cyc  = cyc + ((inst == 0) ? 1 : 3);
        e.data = '0;
        e.err  = 1'b0;
        e.chk  = !w;
        k = longint'(a >> 3);
        if (a < 64'h8000_0000) begin
            if (w) e.err = 1'b1;
            else   e.data = {a[63:32] ^ 32'hB007_B007, a[31:0] & 32'hFFFF_FFF8};
        end else if (a >= 64'h8008_0000) begin
            e.err = 1'b1;
        end else begin
            if (inst == 0) old = mdl1.exists(k) ? mdl1[k] : 'x;
            else           old = mdl3.exists(k) ? mdl3[k] : 'x;
            if (w) begin
                for (int i = 0; i < 8; i++) if (b[i]) old[i*8 +: 8] = d[i*8 +: 8];
                if (inst == 0) mdl1[k] = old;
                else           mdl3[k] = old;
            end else begin
                e.data = old;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin : mon
        logic v, er;
        logic [63:0] d;
        resp_t e;
        if (mon_en) begin
            for (int n = 0; n < 2; n++) begin
                for (int p = 0; p < 2; p++) begin
                    v  = (n == 0) ? rv1[p] : rv3[p];
                    er = (n == 0) ? er1[p] : er3[p];
                    d  = (n == 0) ? rd1[p] : rd3[p];
                    cmp++;
                    if (v === 1'b1) begin
                        cnt[n][p]++;
                        if (sb[n].size() == 0) begin
                            bad++;
                            $display("FAIL rsp_unexpected inst%0d port%0d cyc %0d: data %h err %b, no response required",
                                     n, p, cyc, d, er);
                        end else begin
                            e = sb[n].pop_front();
                            if (e.port != p || e.cyc != cyc || er !== e.err || (e.chk && d !== e.data)) begin
                                bad++;
                                $display("FAIL rsp inst%0d: got port %0d cyc %0d data %h err %b, want port %0d cyc %0d data %h err %b",
                                         n, p, cyc, d, er, e.port, e.cyc, e.data, e.err);
                            end
                        end
                    end else if (v !== 1'b0 || d !== 64'h0) begin
                        bad++;
                        $display("FAIL rsp_idle inst%0d port%0d: rvalid %b rdata %h, want 0/0", n, p, v, d);
                    end
                end
            end
        end
    end

    // Drives one request for one cycle (entered and left at a negedge).
    task automatic access(input int inst, input int p, input logic [63:0] a, input bit w,
                          input logic [7:0] b, input logic [63:0] d);
        logic [1:0] g, want;
        addr[p] = a; we[p] = w; be[p] = b; wdata[p] = d;
        req1 = '0; req3 = '0;
        if (inst == 0) req1[p] = 1'b1;
        else           req3[p] = 1'b1;
        #1;
        g = (inst == 0) ? gnt1 : gnt3;
        want = 2'(1 << p);
        cmp++;
        if (g !== want) begin
            bad++;
            $display("FAIL gnt inst%0d port%0d addr %h: got %b want %b", inst, p, a, g, want);
        end
        sb[inst].push_back(model(inst, p, a, w, b, d));
        @(negedge clk);
        req1 = '0; req3 = '0;
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        req1 = 2'b11; req3 = 2'b11;
        repeat (3) @(negedge clk);
        cmp++;
        if (gnt1 !== 2'b00 || gnt3 !== 2'b00) begin
            bad++; $display("FAIL reset_gnt: got %b/%b want 00/00", gnt1, gnt3);
        end
        cmp++;
        if (rv1 !== 2'b00 || rv3 !== 2'b00) begin
            bad++; $display("FAIL reset_rvalid: got %b/%b want 00/00", rv1, rv3);
        end
        cmp++;
        if (er1 !== 2'b00 || er3 !== 2'b00) begin
            bad++; $display("FAIL reset_err: got %b/%b want 00/00", er1, er3);
        end
        cmp++;
        if (rd1 !== '0 || rd3 !== '0) begin
            bad++; $display("FAIL reset_rdata: got %h/%h want 0", rd1, rd3);
        end
        req1 = '0; req3 = '0;
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        access(0, 0, 64'h8000_0010, 1'b1, 8'hFF, 64'hDEADBEEF_CAFEF00D);
        access(0, 0, 64'h8000_0010, 1'b0, 8'h00, 64'h0);
        drain();
    endtask

    task automatic test_byte_en();
        access(0, 0, 64'h8000_0010, 1'b1, 8'h0F, 64'h11111111_22222222);
        access(0, 0, 64'h8000_0010, 1'b0, 8'h00, 64'h0);
        access(0, 1, 64'h8000_0010, 1'b1, 8'hC0, 64'h5A5A_0000_0000_0000);
        access(0, 0, 64'h8000_0010, 1'b0, 8'h00, 64'h0);
        drain();
    endtask

    task automatic test_arbitration();
        int w;
        logic [1:0] want;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt[0][0] = 0; cnt[0][1] = 0;
        addr[0] = 64'h8000_0010; we[0] = 1'b0; be[0] = '0;
        addr[1] = 64'h0000_0200; we[1] = 1'b0; be[1] = '0;
        req1 = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            w = i % 2;
            want = 2'(1 << w);
            cmp++;
            if (gnt1 !== want) begin
                bad++; $display("FAIL arb cycle %0d: got %b want %b", i, gnt1, want);
            end
            sb[0].push_back(model(0, w, addr[w], 1'b0, 8'h00, 64'h0));
            @(negedge clk);
        end
        req1 = '0;
        drain();
        cmp++;
        if (cnt[0][0] != 3 || cnt[0][1] != 3) begin
            bad++; $display("FAIL arb_count: got %0d/%0d rvalids want 3/3", cnt[0][0], cnt[0][1]);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            access(1, 1, 64'h8000_0000 + 64'(8 * i), 1'b1, 8'hFF, 64'hA5A5_0000_0000_1000 + 64'(i));
        for (int i = 0; i < 4; i++)
            access(1, 1, 64'h8000_0000 + 64'(8 * i), 1'b0, 8'h00, 64'h0);
        drain();
    endtask

    task automatic test_errors();
        access(0, 0, 64'h0000_1000, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        access(0, 0, 64'h0000_1000, 1'b0, 8'h00, 64'h0);
        access(0, 1, 64'h8800_0000, 1'b0, 8'h00, 64'h0);
        access(0, 0, 64'h8007_FFF8, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF);
        access(0, 1, 64'h8007_FFF8, 1'b0, 8'h00, 64'h0);
        access(0, 0, 64'h8008_0000, 1'b1, 8'hFF, 64'h1);
        access(0, 1, 64'h8008_0000, 1'b0, 8'h00, 64'h0);
        access(0, 0, 64'h7FFF_FFF8, 1'b0, 8'h00, 64'h0);
        drain();
    endtask

    task automatic test_reset_midop();
        access(1, 1, 64'h8000_0000, 1'b0, 8'h00, 64'h0);
        access(1, 1, 64'h8000_0008, 1'b0, 8'h00, 64'h0);
        rst_n = 1'b0;
        sb[1].delete();
        addr[0] = 64'h8000_0008; we[0] = 1'b0;
        addr[1] = 64'h8000_0010; we[1] = 1'b0;
        req3 = 2'b11;
        repeat (3) begin
            #1;
            cmp++;
            if (gnt3 !== 2'b00) begin
                bad++; $display("FAIL midop_reset_gnt: got %b want 00", gnt3);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        #1;
        cmp++;
        if (gnt3 !== 2'b01) begin
            bad++; $display("FAIL midop_first_gnt: got %b want 01", gnt3);
        end
        sb[1].push_back(model(1, 0, addr[0], 1'b0, 8'h00, 64'h0));
        @(negedge clk);
        req3 = '0;
        drain();
    endtask

    initial begin
        for (int n = 0; n < 2; n++) begin
            cnt[n][0] = 0; cnt[n][1] = 0;
        end
        @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_en();
        test_arbitration();
        test_back_to_back();
        test_errors();
        test_reset_midop();
        for (int n = 0; n < 2; n++) begin
            cmp++;
            if (sb[n].size() != 0) begin
                bad++; $display("FAIL missing_rsp inst%0d: %0d outstanding, want 0", n, sb[n].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
